multicycle_mem_responder: RTL and testbench
===========================================

// Module: multicycle_mem_responder
// PURPOSE
//  Memory-side responder for the multicycle CPU controller's memory strobes.
//  Serves MemToRead/MemToWrite requests from a unified instruction/data word
//  memory, selecting PC (fetch) or ALUOut (load/store) by IorD.
//  Inserts configurable wait states and returns a one-cycle mem_ready pulse so
//  the controller FSM can hold its current state until the access completes.
// PARAMETERS
//  DATA_WIDTH   32  data word width (bits)
//  ADDR_WIDTH   8   word-index width; memory depth = 2**ADDR_WIDTH words
//  WAIT_CYCLES  2   wait states between accept and completion (0..15)
// PORTS
//  clk         in   1           rising-edge clock
//  rst         in   1           synchronous, active-high reset
//  MemToRead   in   1           read request strobe from controller
//  MemToWrite  in   1           write request strobe from controller
//  IorD        in   1           0: address = PC, 1: address = ALUOut
//  PC          in   32          byte address for instruction fetch
//  ALUOut      in   32          byte address for data access
//  WriteData   in   DATA_WIDTH  store data (register B)
//  MemData     out  DATA_WIDTH  read data; holds until next read completes
//  mem_ready   out  1           one-cycle completion pulse
//  mem_busy    out  1           high while an access is in flight
//  addr_err    out  1           one-cycle pulse: rejected request
// BEHAVIOUR
//  - Reset: state=IDLE, MemData=0, mem_ready=0, mem_busy=0, addr_err=0,
//    wait counter=0. Memory array contents are NOT cleared by rst.
//  - Address: addr = IorD ? ALUOut : PC; word index = addr[ADDR_WIDTH+1:2].
//  - FSM states IDLE, WAIT, DONE:
//    IDLE: if exactly one strobe is high and the request is legal -> accept:
//      capture addr, WriteData, op; counter <= WAIT_CYCLES; mem_busy <= 1;
//      go WAIT (or straight to DONE if WAIT_CYCLES == 0).
//    WAIT: counter decrements each cycle; at counter == 1 -> DONE.
//      Strobe/address/data changes during WAIT are ignored (captured values used).
//    DONE: mem_ready=1 for exactly this cycle; read: MemData <= mem[idx];
//      write: mem[idx] <= captured data (commit happens only here);
//      mem_busy <= 0; next state IDLE.
//  - Latency: mem_ready is high WAIT_CYCLES+1 cycles after the accept edge.
//  - Controller must drop its strobe in the cycle it samples mem_ready; a
//    strobe still high in IDLE starts a new access (no dedup).
//  - Illegal request in IDLE -> addr_err pulse for 1 cycle, no access, no
//    mem_ready, state stays IDLE, MemData unchanged:
//    * misaligned: addr[1:0] != 0
//    * out of range: addr[31:ADDR_WIDTH+2] != 0
//    * MemToRead and MemToWrite both high
//    An illegal request held high re-flags addr_err every cycle.
//  - Write then read of same word: read returns newly written data.
//  - rst mid-access: abort immediately; pending write is NOT committed; no
//    mem_ready; MemData cleared to 0.
//  - Read with no prior write returns array contents (X in sim unless preloaded).
// TESTING
//  1. WAIT_CYCLES=2: write 0xDEADBEEF via IorD=1, ALUOut=0x10 -> mem_ready on
//     3rd edge after accept, mem_busy high 3 cycles; read 0x10 -> MemData=0xDEADBEEF.
//  2. Fetch IorD=0, PC=0x10 while ALUOut=0x44 -> MemData=0xDEADBEEF (PC used);
//     change PC mid-WAIT to 0x20 -> result unaffected.
//  3. ALUOut=0x12 write; then ALUOut=0x400 (ADDR_WIDTH=8) read; then both
//     strobes high -> addr_err pulse each, no mem_ready, word 0x10 unchanged.
//  4. Write 0x12345678 to 0x08, assert rst during WAIT -> mem_ready never
//     pulses, MemData=0, subsequent read of 0x08 != 0x12345678.
//  5. WAIT_CYCLES=0: back-to-back reads 0x00,0x04 with strobe dropped on ready
//     -> mem_ready one cycle after each accept, MemData updates each DONE.
//  6. Strobe held high after mem_ready -> second access accepted next IDLE
//     cycle, second mem_ready WAIT_CYCLES+1 cycles later.

Source files
------------

// File: rtl/multicycle_mem_responder_if.sv
// Request/response bundle between the multicycle controller and its memory responder.
interface multicycle_mem_responder_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  MemToRead;
  logic                  MemToWrite;
  logic                  IorD;
  logic [31:0]           PC;
  logic [31:0]           ALUOut;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] MemData;
  logic                  mem_ready;
  logic                  mem_busy;
  logic                  addr_err;

  modport master (
    output MemToRead, MemToWrite, IorD, PC, ALUOut, WriteData,
    input  MemData, mem_ready, mem_busy, addr_err
  );

  modport slave (
    input  MemToRead, MemToWrite, IorD, PC, ALUOut, WriteData,
    output MemData, mem_ready, mem_busy, addr_err
  );
endinterface

// File: rtl/multicycle_mem_responder.sv
// Unified instruction/data word memory with configurable wait states and a
// one-cycle completion pulse for the multicycle controller.
module multicycle_mem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_mem_responder_if.slave      bus
);

  localparam int unsigned BUS_W = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  // Zero wait states skip the countdown entirely.
  localparam state_t ACCEPT_NEXT = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   cap_write;
  logic [ADDR_WIDTH-1:0]  cap_idx;
  logic [DATA_WIDTH-1:0]  cap_data;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic [BUS_W-1:0]       addr_c;
  logic [ADDR_WIDTH-1:0]  idx_c;
  logic                   req_c;
  logic                   illegal_c;
  logic                   accept_c;

  // Request decode: address select and legality.
  always_comb begin
    addr_c    = bus.IorD ? bus.ALUOut : bus.PC;
    idx_c     = addr_c[ADDR_WIDTH+1:2];
    req_c     = bus.MemToRead | bus.MemToWrite;
    illegal_c = req_c & ((bus.MemToRead & bus.MemToWrite)
                         | (addr_c[1:0] != 2'b00)
                         | ((addr_c >> (ADDR_WIDTH + 2)) != '0));
    accept_c  = req_c & ~illegal_c;
  end

  // Access sequencer; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      cap_write     <= 1'b0;
      cap_idx       <= '0;
      cap_data      <= '0;
      bus.MemData   <= '0;
      bus.mem_ready <= 1'b0;
      bus.mem_busy  <= 1'b0;
      bus.addr_err  <= 1'b0;
    end else begin
      bus.mem_ready <= 1'b0;
      bus.addr_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            cap_write    <= bus.MemToWrite;
            cap_idx      <= idx_c;
            cap_data     <= bus.WriteData;
            cnt          <= CNT_W'(WAIT_CYCLES);
            bus.mem_busy <= 1'b1;
            state        <= ACCEPT_NEXT;
          end else if (illegal_c) begin
            bus.addr_err <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          bus.mem_ready <= 1'b1;
          bus.mem_busy  <= 1'b0;
          if (!cap_write) begin
            bus.MemData <= mem[cap_idx];
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array is never reset; a write commits only on the completion cycle.
  always_ff @(posedge clk) begin
    if (!rst && state == S_DONE && cap_write) begin
      mem[cap_idx] <= cap_data;
    end
  end

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) against a word-array model.
module tb_multicycle_mem_responder;

  localparam bit SEL2 = 1'b0;
  localparam bit SEL0 = 1'b1;

  logic clk;
  logic rst2;
  logic rst0;
  int   n_checks;
  int   n_fail;

  multicycle_mem_responder_if #(.DATA_WIDTH(32)) if2 ();
  multicycle_mem_responder_if #(.DATA_WIDTH(32)) if0 ();

  multicycle_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst2), .bus(if2.slave));
  multicycle_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .bus(if0.slave));

  // Reference: per-responder word array plus last read result.
  logic [31:0] mdl_mem [2][256];
  bit          mdl_vld [2][256];
  logic [31:0] mdl_md  [2];
  int          wc      [2];

  always #5 clk = ~clk;

  task automatic drive(input bit sel, input logic rd, input logic wr, input logic iord,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd);
    if (sel == SEL0) begin
      if0.MemToRead = rd; if0.MemToWrite = wr; if0.IorD = iord;
      if0.PC = pc; if0.ALUOut = alu; if0.WriteData = wd;
    end else begin
      if2.MemToRead = rd; if2.MemToWrite = wr; if2.IorD = iord;
      if2.PC = pc; if2.ALUOut = alu; if2.WriteData = wd;
    end
  endtask

  task automatic sample(input bit sel, output logic rdy, output logic busy,
                        output logic err, output logic [31:0] md);
    if (sel == SEL0) begin
      rdy = if0.mem_ready; busy = if0.mem_busy; err = if0.addr_err; md = if0.MemData;
    end else begin
      rdy = if2.mem_ready; busy = if2.mem_busy; err = if2.addr_err; md = if2.MemData;
    end
  endtask

  // Present one request for up to ncyc edges; n counts edges since the request appeared.
  task automatic run_req(input bit sel, input logic rd, input logic wr, input logic iord,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                         input int ncyc, input bit stop_on_ready,
                         input int chg_n, input logic [31:0] chg_pc,
                         output int first_n, output int last_n, output int rdy_cnt,
                         output int busy_cnt, output int err_cnt, output logic [31:0] md);
    logic rdy, busy, err;
    first_n = 0; last_n = 0; rdy_cnt = 0; busy_cnt = 0; err_cnt = 0; md = '0;
    drive(sel, rd, wr, iord, pc, alu, wd);
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk); #1;
      sample(sel, rdy, busy, err, md);
      if (rdy) begin
        rdy_cnt++;
        if (first_n == 0) first_n = n;
        last_n = n;
      end
      if (busy) busy_cnt++;
      if (err) err_cnt++;
      if (n == chg_n) drive(sel, rd, wr, iord, chg_pc, alu, wd);
      if (rdy && stop_on_ready) break;
    end
    drive(sel, 1'b0, 1'b0, iord, pc, alu, wd);
    @(posedge clk); #1;
  endtask

  // Legal access: fixed latency, busy span, single pulse, and data per the model.
  task automatic legal_access(input bit sel, input bit is_wr, input logic iord,
                              input logic [31:0] pc, input logic [31:0] alu,
                              input logic [31:0] wd, input int chg_n,
                              input logic [31:0] chg_pc, input string tag);
    int f, l, rc, bc, ec;
    logic [31:0] md;
    logic [31:0] a;
    int idx;
    a   = iord ? alu : pc;
    idx = int'(a[9:2]);
    run_req(sel, !is_wr, is_wr, iord, pc, alu, wd, 20, 1'b1, chg_n, chg_pc, f, l, rc, bc, ec, md);
    n_checks++;
    if (f !== wc[sel] + 2 || rc !== 1) begin
      n_fail++;
      $display("FAIL %s latency: ready at edge %0d (count %0d), want edge %0d once", tag, f, rc, wc[sel] + 2);
    end
    n_checks++;
    if (bc !== wc[sel] + 1 || ec !== 0) begin
      n_fail++;
      $display("FAIL %s busy/err: busy %0d cycles err %0d, want %0d and 0", tag, bc, ec, wc[sel] + 1);
    end
    if (is_wr) begin
      mdl_mem[sel][idx] = wd;
      mdl_vld[sel][idx] = 1'b1;
    end else begin
      mdl_md[sel] = mdl_mem[sel][idx];
    end
    n_checks++;
    if (md !== mdl_md[sel]) begin
      n_fail++;
      $display("FAIL %s data: MemData %h, want %h", tag, md, mdl_md[sel]);
    end
  endtask

  // Illegal request held 3 cycles: addr_err every cycle, nothing else moves.
  task automatic illegal_access(input bit sel, input logic rd, input logic wr, input logic iord,
                                input logic [31:0] pc, input logic [31:0] alu, input string tag);
    int f, l, rc, bc, ec;
    logic [31:0] md;
    run_req(sel, rd, wr, iord, pc, alu, 32'hBAD0BAD0, 3, 1'b0, 0, '0, f, l, rc, bc, ec, md);
    n_checks++;
    if (ec !== 3 || rc !== 0 || bc !== 0) begin
      n_fail++;
      $display("FAIL %s reject: err %0d ready %0d busy %0d, want 3 0 0", tag, ec, rc, bc);
    end
    n_checks++;
    if (md !== mdl_md[sel]) begin
      n_fail++;
      $display("FAIL %s MemData held: %h, want %h", tag, md, mdl_md[sel]);
    end
  endtask

  task automatic test_reset();
    logic rdy, busy, err;
    logic [31:0] md;
    rst2 = 1'b1; rst0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sample(s[0], rdy, busy, err, md);
      n_checks++;
      if (rdy !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || md !== 32'h0) begin
        n_fail++;
        $display("FAIL reset[%0d]: ready %b busy %b err %b MemData %h, want 0 0 0 0", s, rdy, busy, err, md);
      end
    end
    rst2 = 1'b0; rst0 = 1'b0;
    mdl_md[0] = '0; mdl_md[1] = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    legal_access(SEL2, 1'b1, 1'b1, 32'h0, 32'h10, 32'hDEADBEEF, 0, '0, "wr_0x10");
    legal_access(SEL2, 1'b0, 1'b1, 32'h0, 32'h10, 32'h0, 0, '0, "rd_0x10");
  endtask

  task automatic test_fetch_pc();
    legal_access(SEL2, 1'b0, 1'b0, 32'h10, 32'h44, 32'h0, 1, 32'h20, "fetch_pc");
  endtask

  task automatic test_illegal();
    illegal_access(SEL2, 1'b0, 1'b1, 1'b1, 32'h0, 32'h12, "misaligned");
    illegal_access(SEL2, 1'b1, 1'b0, 1'b1, 32'h0, 32'h400, "out_of_range");
    illegal_access(SEL2, 1'b1, 1'b1, 1'b1, 32'h0, 32'h10, "both_strobes");
    legal_access(SEL2, 1'b0, 1'b1, 32'h0, 32'h10, 32'h0, 0, '0, "rd_after_illegal");
  endtask

  task automatic test_reset_abort();
    logic rdy, busy, err;
    logic [31:0] md;
    int rcnt;
    legal_access(SEL2, 1'b1, 1'b1, 32'h0, 32'h08, 32'hA5A5A5A5, 0, '0, "wr_0x08");
    rcnt = 0;
    drive(SEL2, 1'b0, 1'b1, 1'b1, 32'h0, 32'h08, 32'h12345678);
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      sample(SEL2, rdy, busy, err, md);
      if (rdy) rcnt++;
      if (n == 2) rst2 = 1'b1;
      if (n == 3) begin
        n_checks++;
        if (busy !== 1'b0 || md !== 32'h0) begin
          n_fail++;
          $display("FAIL abort state: busy %b MemData %h, want 0 0", busy, md);
        end
        rst2 = 1'b0;
        drive(SEL2, 1'b0, 1'b0, 1'b1, 32'h0, 32'h08, 32'h0);
      end
    end
    mdl_md[SEL2] = '0;
    n_checks++;
    if (rcnt !== 0) begin
      n_fail++;
      $display("FAIL abort ready: %0d pulses, want 0", rcnt);
    end
    legal_access(SEL2, 1'b0, 1'b1, 32'h0, 32'h08, 32'h0, 0, '0, "rd_0x08_after_abort");
  endtask

  task automatic test_zero_wait();
    legal_access(SEL0, 1'b1, 1'b1, 32'h0, 32'h00, 32'h11111111, 0, '0, "z_wr_0x00");
    legal_access(SEL0, 1'b1, 1'b1, 32'h0, 32'h04, 32'h22222222, 0, '0, "z_wr_0x04");
    legal_access(SEL0, 1'b0, 1'b1, 32'h0, 32'h00, 32'h0, 0, '0, "z_rd_0x00");
    legal_access(SEL0, 1'b0, 1'b1, 32'h0, 32'h04, 32'h0, 0, '0, "z_rd_0x04");
  endtask

  task automatic test_held_strobe();
    int f, l, rc, bc, ec;
    logic [31:0] md;
    run_req(SEL2, 1'b1, 1'b0, 1'b1, 32'h0, 32'h10, 32'h0, 8, 1'b0, 0, '0, f, l, rc, bc, ec, md);
    n_checks++;
    if (rc !== 2 || f !== wc[SEL2] + 2 || l !== 2 * (wc[SEL2] + 2)) begin
      n_fail++;
      $display("FAIL held_strobe: %0d pulses at %0d/%0d, want 2 at %0d/%0d",
               rc, f, l, wc[SEL2] + 2, 2 * (wc[SEL2] + 2));
    end
    mdl_md[SEL2] = mdl_mem[SEL2][4];
    n_checks++;
    if (md !== mdl_md[SEL2]) begin
      n_fail++;
      $display("FAIL held_strobe data: %h, want %h", md, mdl_md[SEL2]);
    end
  endtask

  task automatic test_random();
    bit sel;
    int kind, idx;
    logic iord;
    logic [31:0] a, other, wd;
    for (int it = 0; it < 30; it++) begin
      sel   = 1'($urandom_range(0, 1));
      kind  = int'($urandom_range(0, 5));
      idx   = int'($urandom_range(0, 31));
      iord  = 1'($urandom_range(0, 1));
      wd    = $urandom;
      other = $urandom;
      a     = 32'(idx) << 2;
      if (kind <= 1 && !mdl_vld[sel][idx]) kind = 2;
      case (kind)
        0, 1: legal_access(sel, 1'b0, iord, iord ? other : a, iord ? a : other, wd, 0, '0, "rand_rd");
        2:    legal_access(sel, 1'b1, iord, iord ? other : a, iord ? a : other, wd, 0, '0, "rand_wr");
        3: begin
          a = a | 32'($urandom_range(1, 3));
          illegal_access(sel, 1'b1, 1'b0, iord, iord ? other : a, iord ? a : other, "rand_misalign");
        end
        4: begin
          a = a | (32'($urandom_range(1, 255)) << 10);
          illegal_access(sel, 1'b0, 1'b1, iord, iord ? other : a, iord ? a : other, "rand_range");
        end
        default: illegal_access(sel, 1'b1, 1'b1, iord, iord ? other : a, iord ? a : other, "rand_both");
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; n_checks = 0; n_fail = 0;
    wc[0] = 2; wc[1] = 0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) mdl_vld[s][i] = 1'b0;
    drive(SEL2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    drive(SEL0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    test_reset();
    test_write_read();
    test_fetch_pc();
    test_illegal();
    test_reset_abort();
    test_zero_wait();
    test_held_strobe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
